// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI request arbiter slice.
package spi_arb_pkg;

    localparam int CMD_W         = 64;
    localparam int LEN_W         = 3;
    localparam int CSR_W         = 4;
    localparam int CSR_START_BIT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // Build the controller csr[4:1] control word from a start flag and a length code.
    function automatic logic [CSR_W-1:0] csr_word(input logic start, input logic [LEN_W-1:0] len);
        logic [CSR_W-1:0] w;
        w                = '0;
        w[LEN_W-1:0]     = len;
        w[CSR_START_BIT] = start;
        return w;
    endfunction

endpackage

// File: rtl/spi_request_arbiter_if.sv
// Requester-side bus of the SPI request arbiter: request/command in, grant/done/response out.
interface spi_request_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CMD_W-1:0] req_cmd;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic [CMD_W-1:0]         rsp;
    logic                     err;

    // Requester side: raises requests, receives grants and completions.
    modport master (
        output req, req_cmd, req_len,
        input  gnt, done, rsp, err
    );

    // Arbiter side.
    modport slave (
        input  req, req_cmd, req_len,
        output gnt, done, rsp, err
    );

endinterface

// File: rtl/spi_request_arbiter_rr.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Scan N candidates starting at ptr; the first requesting one wins.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        valid  = 1'b0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int off = 0; off < N; off++) begin
            cand_s      = IDX_W'((int'(ptr) + off) % N);
            hit_s       = req[cand_s] & ~valid;
            gnt[cand_s] = hit_s;
            idx         = hit_s ? cand_s : idx;
            valid       = valid | hit_s;
        end
    end

endmodule

// File: rtl/spi_request_arbiter.sv
// Shares one spi_controller among NUM_REQ requesters: round-robin grant, launch,
// wait for completion (or start timeout), return response to the granted requester.
module spi_request_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_request_arbiter_if.slave bus,
    output logic [CMD_W-1:0]     spi_command,
    output logic [CSR_W-1:0]     spi_csr_ctl,
    input  logic                 spi_busy,
    input  logic [CMD_W-1:0]     spi_response
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_REQ - 1);

    arb_state_e          state_r;
    arb_state_e          state_nxt_s;
    logic [IDX_W-1:0]    ptr_r;
    logic [IDX_W-1:0]    sel_idx_r;
    logic [LEN_W-1:0]    len_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CMD_W-1:0]    cmd_r;
    logic [CSR_W-1:0]    csr_r;
    logic [NUM_REQ-1:0]  gnt_r;
    logic [NUM_REQ-1:0]  done_r;
    logic [CMD_W-1:0]    rsp_r;
    logic                err_r;

    logic [NUM_REQ-1:0]  arb_gnt_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic                arb_valid_s;
    logic [CMD_W-1:0]    arb_cmd_s;
    logic [LEN_W-1:0]    arb_len_s;
    logic                launch_s;
    logic                tmo_s;
    logic [NUM_REQ-1:0]  gnt_nxt_s;
    logic [NUM_REQ-1:0]  done_nxt_s;
    logic                err_nxt_s;
    logic [CSR_W-1:0]    csr_nxt_s;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (bus.req),
        .ptr   (ptr_r),
        .gnt   (arb_gnt_s),
        .idx   (arb_idx_s),
        .valid (arb_valid_s)
    );

    assign arb_cmd_s = bus.req_cmd[arb_idx_s*CMD_W +: CMD_W];
    assign arb_len_s = bus.req_len[arb_idx_s*LEN_W +: LEN_W];

    // Pointer advance after a grant, wrapping the top requester back to 0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
        return (w == IDX_TOP) ? '0 : (w + IDX_W'(1));
    endfunction

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a busy controller in IDLE means foreign use, so no launch.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (arb_valid_s && !spi_busy) begin
                    state_nxt_s = LAUNCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LAUNCH: begin
                if (spi_busy) begin
                    state_nxt_s = WAIT;
                end else if (cnt_r >= CNT_LAST) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = LAUNCH;
                end
            end
            WAIT: begin
                if (!spi_busy) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state; results are registered below.
    always_comb begin
        launch_s   = (state_r == IDLE) && (state_nxt_s == LAUNCH);
        tmo_s      = (state_r == LAUNCH) && !spi_busy && (cnt_r >= CNT_LAST);
        gnt_nxt_s  = '0;
        done_nxt_s = '0;
        err_nxt_s  = 1'b0;
        csr_nxt_s  = '0;
        if (launch_s) begin
            gnt_nxt_s = arb_gnt_s;
        end else begin
            gnt_nxt_s = '0;
        end
        case (state_nxt_s)
            LAUNCH:  csr_nxt_s = csr_word(1'b1, launch_s ? arb_len_s : len_r);
            WAIT:    csr_nxt_s = csr_word(1'b0, len_r);
            RESP: begin
                done_nxt_s = NUM_REQ'(1) << sel_idx_r;
                err_nxt_s  = tmo_s;
            end
            default: csr_nxt_s = '0;
        endcase
    end

    // Grant bookkeeping: latch winner, its command and length, advance the RR pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r     <= '0;
            sel_idx_r <= '0;
            len_r     <= '0;
            cmd_r     <= '0;
        end else if (launch_s) begin
            ptr_r     <= next_ptr(arb_idx_s);
            sel_idx_r <= arb_idx_s;
            len_r     <= arb_len_s;
            cmd_r     <= arb_cmd_s;
        end else begin
            ptr_r     <= ptr_r;
            sel_idx_r <= sel_idx_r;
            len_r     <= len_r;
            cmd_r     <= cmd_r;
        end
    end

    // Start-timeout counter: cleared on entry to LAUNCH, counts LAUNCH cycles, saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (launch_s) begin
            cnt_r <= '0;
        end else if ((state_r == LAUNCH) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered handshake outputs; response is kept on timeout so stale data is not overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_r  <= '0;
            done_r <= '0;
            err_r  <= 1'b0;
            csr_r  <= '0;
            rsp_r  <= '0;
        end else begin
            gnt_r  <= gnt_nxt_s;
            done_r <= done_nxt_s;
            err_r  <= err_nxt_s;
            csr_r  <= csr_nxt_s;
            if ((state_nxt_s == RESP) && !tmo_s) begin
                rsp_r <= spi_response;
            end else begin
                rsp_r <= rsp_r;
            end
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.rsp     = rsp_r;
    assign spi_command = cmd_r;
    assign spi_csr_ctl = csr_r;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Directed bench for spi_request_arbiter with three requesters and a scripted controller.
module tb_spi_request_arbiter;
    import spi_arb_pkg::*;

    localparam int NR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_busy;
    logic [63:0] spi_response;
    logic [63:0] spi_command;
    logic [3:0]  spi_csr_ctl;

    logic [63:0] cmd_a [NR];
    logic [2:0]  len_a [NR];
    logic [63:0] last_rsp;

    int n_cmp = 0;
    int n_bad = 0;

    spi_request_arbiter_if #(.NUM_REQ(NR)) bus ();

    spi_request_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .spi_command  (spi_command),
        .spi_csr_ctl  (spi_csr_ctl),
        .spi_busy     (spi_busy),
        .spi_response (spi_response)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".gnt"},  64'(bus.gnt),  64'd0);
        chk({tag, ".done"}, 64'(bus.done), 64'd0);
        chk({tag, ".err"},  64'(bus.err),  64'd0);
        chk({tag, ".rsp"},  bus.rsp,       64'd0);
        chk({tag, ".cmd"},  spi_command,   64'd0);
        chk({tag, ".csr"},  64'(spi_csr_ctl), 64'd0);
    endtask

    // One full transaction expected to be granted to requester w.
    task automatic txn(input int w, input logic [2:0] rq, input logic [63:0] resp, input string tag);
        logic [2:0] oh;
        oh = 3'b001 << w;
        bus.req = rq;
        step();
        chk({tag, ".gnt"}, 64'(bus.gnt), 64'(oh));
        chk({tag, ".cmd"}, spi_command, cmd_a[w]);
        chk({tag, ".csr"}, 64'(spi_csr_ctl), 64'({1'b1, len_a[w]}));
        spi_busy = 1'b1;
        step();
        chk({tag, ".wait"}, 64'({bus.gnt, bus.done, spi_csr_ctl}), 64'({3'b000, 3'b000, 1'b0, len_a[w]}));
        step();
        spi_busy     = 1'b0;
        spi_response = resp;
        step();
        chk({tag, ".done"}, 64'({bus.gnt, bus.done, bus.err}), 64'({3'b000, oh, 1'b0}));
        chk({tag, ".rsp"}, bus.rsp, resp);
        bus.req = 3'b000;
        step();
        chk({tag, ".idle"}, 64'({bus.gnt, bus.done, spi_csr_ctl}), 64'd0);
        last_rsp = resp;
    endtask

    initial begin
        cmd_a[0] = {8'h03, 24'h001000, 8'h74, 24'h000000};
        cmd_a[1] = 64'h0B00_2000_0000_0011;
        cmd_a[2] = 64'h9F00_0000_0000_0022;
        len_a[0] = 3'd4;
        len_a[1] = 3'd1;
        len_a[2] = 3'd7;
        rst          = 1'b0;
        spi_busy     = 1'b0;
        spi_response = 64'd0;
        last_rsp     = 64'd0;
        bus.req      = 3'b000;
        bus.req_cmd  = {cmd_a[2], cmd_a[1], cmd_a[0]};
        bus.req_len  = {len_a[2], len_a[1], len_a[0]};

        // Reset state
        step();
        step();
        chk_reset_outputs("rst");
        rst = 1'b1;
        step();

        // 1: single requester 0
        txn(0, 3'b001, 64'hDEAD_BEEF_0000_0074, "t1");

        // 2: two requesters held continuously, from a fresh pointer
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        txn(0, 3'b011, 64'h1111_0000_0000_0001, "t2a");
        txn(1, 3'b011, 64'h2222_0000_0000_0002, "t2b");
        txn(0, 3'b011, 64'h3333_0000_0000_0003, "t2c");
        txn(1, 3'b011, 64'h4444_0000_0000_0004, "t2d");

        // 3: pointer wrap after a grant to requester 2
        txn(2, 3'b100, 64'h5555_0000_0000_0005, "t3a");
        txn(0, 3'b101, 64'h6666_0000_0000_0006, "t3b");
        txn(2, 3'b101, 64'h7777_0000_0000_0007, "t3c");

        // 4: controller never goes busy -> timeout after 16 LAUNCH cycles
        bus.req = 3'b010;
        step();
        chk("t4.gnt", 64'(bus.gnt), 64'(3'b010));
        for (int i = 0; i < 15; i++) begin
            step();
        end
        chk("t4.start_held", 64'({bus.done, spi_csr_ctl}), 64'({3'b000, 1'b1, len_a[1]}));
        step();
        chk("t4.done", 64'({bus.done, bus.err}), 64'({3'b010, 1'b1}));
        chk("t4.rsp_kept", bus.rsp, last_rsp);
        bus.req = 3'b000;
        step();
        chk("t4.after", 64'({bus.done, bus.err, spi_csr_ctl}), 64'd0);
        txn(0, 3'b001, 64'h8888_0000_0000_0008, "t4n");

        // 5: reset during WAIT; pending request served after release from pointer 0
        bus.req = 3'b010;
        step();
        chk("t5.gnt", 64'(bus.gnt), 64'(3'b010));
        spi_busy = 1'b1;
        step();
        chk("t5.wait", 64'(spi_csr_ctl), 64'({1'b0, len_a[1]}));
        rst = 1'b0;
        #1;
        chk_reset_outputs("t5.rst");
        spi_busy = 1'b0;
        bus.req  = 3'b110;
        @(negedge clk);
        step();
        chk("t5.held", 64'(bus.gnt), 64'd0);
        rst = 1'b1;
        step();
        chk("t5.regnt", 64'(bus.gnt), 64'(3'b010));
        spi_busy = 1'b1;
        bus.req  = 3'b000;
        step();
        spi_busy     = 1'b0;
        spi_response = 64'h9999_0000_0000_0009;
        step();
        chk("t5.done", 64'({bus.done, bus.rsp}), {3'b010, 64'h9999_0000_0000_0009} & 67'h0_FFFF_FFFF_FFFF_FFFF | 64'd0);
        step();

        // 6: second request arriving during WAIT waits until after done
        bus.req = 3'b001;
        step();
        chk("t6.gnt0", 64'(bus.gnt), 64'(3'b001));
        spi_busy = 1'b1;
        step();
        bus.req = 3'b011;
        step();
        chk("t6.nognt_a", 64'(bus.gnt), 64'd0);
        step();
        chk("t6.nognt_b", 64'(bus.gnt), 64'd0);
        spi_busy     = 1'b0;
        spi_response = 64'hAAAA_0000_0000_000A;
        step();
        chk("t6.done0", 64'({bus.gnt, bus.done}), 64'({3'b000, 3'b001}));
        chk("t6.rsp", bus.rsp, 64'hAAAA_0000_0000_000A);
        bus.req = 3'b010;
        step();
        chk("t6.idle", 64'({bus.gnt, bus.done}), 64'd0);
        step();
        chk("t6.gnt1", 64'(bus.gnt), 64'(3'b010));
        bus.req  = 3'b000;
        spi_busy = 1'b1;
        step();
        spi_busy = 1'b0;
        step();
        chk("t6.done1", 64'(bus.done), 64'(3'b010));
        step();

        // Foreign busy in IDLE blocks launch until it clears
        spi_busy = 1'b1;
        bus.req  = 3'b001;
        step();
        step();
        chk("fb.blocked", 64'({bus.gnt, spi_csr_ctl}), 64'd0);
        spi_busy = 1'b0;
        step();
        chk("fb.gnt", 64'(bus.gnt), 64'(3'b001));
        bus.req  = 3'b000;
        spi_busy = 1'b1;
        step();
        spi_busy = 1'b0;
        step();
        chk("fb.done", 64'(bus.done), 64'(3'b001));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
